// File: rtl/bus_arbiter.sv
// bus_arbiter: shared system-bus interconnect.
// Arbitrates NUM_MASTERS requesters onto one bus (fixed priority or round-robin),
// decodes the winner's address into NUM_SLAVES inclusive [base, limit] regions and
// returns read data one cycle after the grant, matching registered-output slaves.
//
// Ports:
//   clk       - system clock
//   reset_n   - asynchronous active-low reset
//   m_req     - per-master request, held until granted
//   m_addr    - per-master address, master i at [i*ADDR_W +: ADDR_W]
//   m_write   - per-master write strobe
//   m_wdata   - per-master write data, master i at [i*DATA_W +: DATA_W]
//   m_gnt     - one-hot grant, transaction accepted this cycle
//   m_rvalid  - one-hot read-data-valid, one cycle after a read grant
//   m_rdata   - shared read data, holds its last value between reads
//   s_enable  - one-hot slave select
//   s_addr    - shared slave address
//   s_write   - shared slave write strobe
//   s_wdata   - shared slave write data
//   s_rdata   - per-slave registered read data, slave i at [i*DATA_W +: DATA_W]
module bus_arbiter #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned NUM_SLAVES  = 4,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 8,
  // Regions: 0 cart 0000-7FFF, 1 WRAM C000-FDFF, 2 HRAM FF80-FFFE, 3 VRAM 8000-9FFF
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE  = {16'h8000, 16'hFF80, 16'hC000, 16'h0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_LIMIT = {16'h9FFF, 16'hFFFE, 16'hFDFF, 16'h7FFF},
  parameter int unsigned ARB_MODE    = 0,
  parameter logic [DATA_W-1:0] OPEN_BUS = '1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS-1:0]        m_write,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_gnt,
  output logic [NUM_MASTERS-1:0]        m_rvalid,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [NUM_SLAVES-1:0]         s_enable,
  output logic [ADDR_W-1:0]             s_addr,
  output logic                          s_write,
  output logic [DATA_W-1:0]             s_wdata,
  input  logic [NUM_SLAVES*DATA_W-1:0]  s_rdata
);

  localparam int unsigned MIDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned SIDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  // Round-robin pointer and the read transaction latched at the grant edge
  logic [MIDX_W-1:0] r_ptr;
  logic              r_rd_pend;
  logic [MIDX_W-1:0] r_rd_mst;
  logic [SIDX_W-1:0] r_rd_slv;
  logic              r_rd_unmapped;
  logic [DATA_W-1:0] r_rdata_hold;

  logic              w_win_vld;
  logic [MIDX_W-1:0] w_win_idx;
  int                w_cand;
  logic [ADDR_W-1:0] w_addr;
  logic              w_wr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_hit;
  logic [SIDX_W-1:0] w_slv;
  logic              w_active;
  logic              w_sel;
  logic [DATA_W-1:0] w_rd_live;
  logic [MIDX_W-1:0] w_ptr_nxt;

  // Arbitration
  always_comb begin
    w_win_vld = 1'b0;
    w_win_idx = '0;
    w_cand    = 0;
    if (ARB_MODE == 0) begin
      // Ascending scan: the highest requesting index is the last one assigned
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (m_req[i]) begin
          w_win_vld = 1'b1;
          w_win_idx = MIDX_W'(i);
        end
      end
    end else begin
      // Scan offsets from farthest to nearest so the first requester at/after
      // the pointer (with wrap) is the last one assigned
      for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
        w_cand = int'(r_ptr) + k;
        if (w_cand >= int'(NUM_MASTERS)) begin
          w_cand = w_cand - int'(NUM_MASTERS);
        end
        if (m_req[MIDX_W'(w_cand)]) begin
          w_win_vld = 1'b1;
          w_win_idx = MIDX_W'(w_cand);
        end
      end
    end
  end

  assign w_ptr_nxt = (w_win_idx == MIDX_W'(NUM_MASTERS - 1)) ? '0 : w_win_idx + 1'b1;

  // Winner's request fields
  always_comb begin
    w_addr  = '0;
    w_wr    = 1'b0;
    w_wdata = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (w_win_idx == MIDX_W'(i)) begin
        w_addr  = m_addr[i*ADDR_W +: ADDR_W];
        w_wr    = m_write[i];
        w_wdata = m_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Address decode; descending scan so overlapping regions resolve to the lowest index
  always_comb begin
    w_hit = 1'b0;
    w_slv = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((w_addr >= SLV_BASE[i*ADDR_W +: ADDR_W]) &&
          (w_addr <= SLV_LIMIT[i*ADDR_W +: ADDR_W])) begin
        w_hit = 1'b1;
        w_slv = SIDX_W'(i);
      end
    end
  end

  // Grant and slave drive are suppressed while reset is held
  assign w_active = reset_n & w_win_vld;
  assign w_sel    = w_active & w_hit;

  always_comb begin
    m_gnt    = '0;
    s_enable = '0;
    if (w_active) begin
      m_gnt[w_win_idx] = 1'b1;
    end
    if (w_sel) begin
      s_enable[w_slv] = 1'b1;
    end
  end

  assign s_addr  = w_sel ? w_addr : '0;
  assign s_write = w_sel & w_wr;
  assign s_wdata = w_sel ? w_wdata : '0;

  // Read return path
  always_comb begin
    w_rd_live = OPEN_BUS;
    if (!r_rd_unmapped) begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (r_rd_slv == SIDX_W'(i)) begin
          w_rd_live = s_rdata[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign m_rdata = r_rd_pend ? w_rd_live : r_rdata_hold;

  always_comb begin
    m_rvalid = '0;
    if (r_rd_pend) begin
      m_rvalid[r_rd_mst] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr         <= '0;
      r_rd_pend     <= 1'b0;
      r_rd_mst      <= '0;
      r_rd_slv      <= '0;
      r_rd_unmapped <= 1'b0;
      r_rdata_hold  <= '0;
    end else begin
      if ((ARB_MODE != 0) && w_win_vld) begin
        r_ptr <= w_ptr_nxt;
      end
      // Capture the value shown this cycle so it persists after rvalid drops
      if (r_rd_pend) begin
        r_rdata_hold <= w_rd_live;
      end
      r_rd_pend <= w_win_vld & ~w_wr;
      if (w_win_vld && !w_wr) begin
        r_rd_mst      <= w_win_idx;
        r_rd_slv      <= w_hit ? w_slv : '0;
        r_rd_unmapped <= ~w_hit;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [1:0]       m_req;
  logic [31:0]      m_addr;
  logic [1:0]       m_write;
  logic [15:0]      m_wdata;

  // Index 0: fixed-priority instance, default map.
  // Index 1: round-robin instance, slave 3 = 4000-9FFF overlapping slave 0.
  logic [1:0][1:0]  gnt;
  logic [1:0][1:0]  rv;
  logic [1:0][7:0]  rd;
  logic [1:0][3:0]  en;
  logic [1:0][15:0] sa;
  logic [1:0]       sw;
  logic [1:0][7:0]  swd;
  logic [1:0][31:0] srd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.ARB_MODE(0)) u_fixed (
    .clk(clk), .reset_n(reset_n), .m_req(m_req), .m_addr(m_addr), .m_write(m_write),
    .m_wdata(m_wdata), .m_gnt(gnt[0]), .m_rvalid(rv[0]), .m_rdata(rd[0]),
    .s_enable(en[0]), .s_addr(sa[0]), .s_write(sw[0]), .s_wdata(swd[0]), .s_rdata(srd[0])
  );

  bus_arbiter #(
    .ARB_MODE (1),
    .SLV_BASE ({16'h4000, 16'hFF80, 16'hC000, 16'h0000}),
    .SLV_LIMIT({16'h9FFF, 16'hFFFE, 16'hFDFF, 16'h7FFF})
  ) u_rr (
    .clk(clk), .reset_n(reset_n), .m_req(m_req), .m_addr(m_addr), .m_write(m_write),
    .m_wdata(m_wdata), .m_gnt(gnt[1]), .m_rvalid(rv[1]), .m_rdata(rd[1]),
    .s_enable(en[1]), .s_addr(sa[1]), .s_write(sw[1]), .s_wdata(swd[1]), .s_rdata(srd[1])
  );

  // Slave memories driven only by the DUT's slave-side signals
  logic [7:0] mem [2][4][65536];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 4; s++) begin
        if (en[d][s]) begin
          if (sw[d]) mem[d][s][sa[d]] = swd[d];
          else srd[d][s*8 +: 8] <= mem[d][s][sa[d]];
        end
      end
    end
  end

  // Reference model: region tables, memory image and in-flight read per instance
  int         base_tab  [2][4] = '{'{'h0000, 'hC000, 'hFF80, 'h8000},
                                   '{'h0000, 'hC000, 'hFF80, 'h4000}};
  int         limit_tab [2][4] = '{'{'h7FFF, 'hFDFF, 'hFFFE, 'h9FFF},
                                   '{'h7FFF, 'hFDFF, 'hFFFE, 'h9FFF}};
  logic [7:0] ref_mem [2][4][65536];
  int         ptr       [2];
  bit         pend      [2];
  int         pend_m    [2];
  logic [7:0] pend_data [2];
  logic [7:0] last_rd   [2];

  function automatic int ref_decode(input int d, input int addr);
    for (int s = 0; s < 4; s++) begin
      if (base_tab[d][s] <= addr && addr <= limit_tab[d][s]) return s;
    end
    return -1;
  endfunction

  function automatic int ref_winner(input int d, input logic [1:0] req);
    if (req == 2'b00) return -1;
    if (d == 0) return req[1] ? 1 : 0;
    for (int k = 0; k < 2; k++) begin
      if (req[(ptr[d] + k) % 2]) return (ptr[d] + k) % 2;
    end
    return -1;
  endfunction

  function automatic logic [15:0] pick_addr();
    logic [15:0] tab [13];
    tab = '{16'h0000, 16'h7FFF, 16'h8000, 16'hC000, 16'hFDFF, 16'hFE00, 16'hFF7F,
            16'hFF80, 16'hFFFE, 16'hFFFF, 16'h4000, 16'h9FFF, 16'hA000};
    if ($urandom_range(0, 1) == 1) return tab[$urandom_range(0, 12)];
    return 16'($urandom);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      ptr[d] = 0; pend[d] = 1'b0; pend_m[d] = 0; pend_data[d] = 8'h00; last_rd[d] = 8'h00;
    end
  endtask

  // Advance the model over the coming clock edge, then wait for that edge
  task automatic step();
    int w, s, a;
    for (int d = 0; d < 2; d++) begin
      if (pend[d]) last_rd[d] = pend_data[d];
      pend[d] = 1'b0;
      w = ref_winner(d, m_req);
      if (w >= 0) begin
        a = int'(m_addr[w*16 +: 16]);
        s = ref_decode(d, a);
        if (d == 1) ptr[d] = (w + 1) % 2;
        if (m_write[w]) begin
          if (s >= 0) ref_mem[d][s][a] = m_wdata[w*8 +: 8];
        end else begin
          pend[d]      = 1'b1;
          pend_m[d]    = w;
          pend_data[d] = (s >= 0) ? ref_mem[d][s][a] : 8'hFF;
        end
      end
    end
    @(posedge clk);
  endtask

  task automatic drive(input logic [1:0] req, input logic [15:0] a0, input logic [15:0] a1,
                       input logic [1:0] wr, input logic [7:0] d0, input logic [7:0] d1);
    @(negedge clk);
    m_req = req; m_addr = {a1, a0}; m_write = wr; m_wdata = {d1, d0};
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    m_req = 2'b00; m_write = 2'b00;
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    m_req = 2'b11; m_addr = {16'hC000, 16'h0010}; m_write = 2'b01; m_wdata = 16'h1234;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({gnt[d], en[d], sw[d], rv[d], rd[d]} !== 17'h0) begin
        n_fail++;
        $display("FAIL reset_outputs dut%0d: got gnt=%b en=%b sw=%b rv=%b rd=%h required all 0",
                 d, gnt[d], en[d], sw[d], rv[d], rd[d]);
      end
    end
    m_req = 2'b00; m_write = 2'b00;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_single_master();
    drive(2'b01, 16'hC123, 16'h0000, 2'b01, 8'hA5, 8'h00);
    n_checks++;
    if ({gnt[0], en[0], sa[0], sw[0], swd[0]} !== {2'b01, 4'b0010, 16'hC123, 1'b1, 8'hA5}) begin
      n_fail++;
      $display("FAIL single_write: got gnt=%b en=%b sa=%h sw=%b swd=%h required 01 0010 c123 1 a5",
               gnt[0], en[0], sa[0], sw[0], swd[0]);
    end
    step();
    drive(2'b01, 16'hC123, 16'h0000, 2'b00, 8'h00, 8'h00);
    n_checks++;
    if ({gnt[0], en[0], sw[0], rv[0]} !== {2'b01, 4'b0010, 1'b0, 2'b00}) begin
      n_fail++;
      $display("FAIL single_read_req: got gnt=%b en=%b sw=%b rv=%b required 01 0010 0 00",
               gnt[0], en[0], sw[0], rv[0]);
    end
    step();
    drive(2'b00, 16'h0000, 16'h0000, 2'b00, 8'h00, 8'h00);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({gnt[d], rv[d], rd[d]} !== {2'b00, 2'b01, 8'hA5}) begin
        n_fail++;
        $display("FAIL single_read_data dut%0d: got gnt=%b rv=%b rd=%h required 00 01 a5",
                 d, gnt[d], rv[d], rd[d]);
      end
    end
    step();
  endtask

  task automatic test_unmapped();
    drive(2'b01, 16'hFEA0, 16'h0000, 2'b00, 8'h00, 8'h00);
    n_checks++;
    if ({gnt[0], en[0], sa[0]} !== {2'b01, 4'b0000, 16'h0000}) begin
      n_fail++;
      $display("FAIL unmapped_read_req: got gnt=%b en=%b sa=%h required 01 0000 0000",
               gnt[0], en[0], sa[0]);
    end
    step();
    drive(2'b01, 16'hFEA0, 16'h0000, 2'b01, 8'h3C, 8'h00);
    n_checks++;
    if ({en[0], sw[0], swd[0], rv[0], rd[0]} !== {4'b0000, 1'b0, 8'h00, 2'b01, 8'hFF}) begin
      n_fail++;
      $display("FAIL unmapped_write_and_data: got en=%b sw=%b swd=%h rv=%b rd=%h required 0000 0 00 01 ff",
               en[0], sw[0], swd[0], rv[0], rd[0]);
    end
    step();
    drive(2'b00, 16'h0000, 16'h0000, 2'b00, 8'h00, 8'h00);
    n_checks++;
    if ({rv[0], rd[0]} !== {2'b00, 8'hFF}) begin
      n_fail++;
      $display("FAIL unmapped_hold: got rv=%b rd=%h required 00 ff", rv[0], rd[0]);
    end
    step();
  endtask

  task automatic test_fixed_priority();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 16'hC000, 16'h0010, 2'b00, 8'h00, 8'h00);
      n_checks++;
      if ({gnt[0], sa[0], rv[0]} !== {2'b10, 16'h0010, (k == 0) ? 2'b00 : 2'b10}) begin
        n_fail++;
        $display("FAIL fixed_prio[%0d]: got gnt=%b sa=%h rv=%b required gnt=10 sa=0010 rv=%b",
                 k, gnt[0], sa[0], rv[0], (k == 0) ? 2'b00 : 2'b10);
      end
      if (k > 0) begin
        n_checks++;
        if (rd[0] !== ref_mem[0][0][16'h0010]) begin
          n_fail++;
          $display("FAIL fixed_prio_data[%0d]: got %h required %h", k, rd[0],
                   ref_mem[0][0][16'h0010]);
        end
      end
      step();
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g, exp_r;
    logic [7:0] exp_d;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      if (k < 4) drive(2'b11, 16'hC000, 16'h0010, 2'b00, 8'h00, 8'h00);
      else drive(2'b00, 16'h0000, 16'h0000, 2'b00, 8'h00, 8'h00);
      exp_g = (k == 4) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10);
      exp_r = (k == 0) ? 2'b00 : ((k % 2 == 1) ? 2'b01 : 2'b10);
      n_checks++;
      if ({gnt[1], rv[1]} !== {exp_g, exp_r}) begin
        n_fail++;
        $display("FAIL round_robin[%0d]: got gnt=%b rv=%b required gnt=%b rv=%b",
                 k, gnt[1], rv[1], exp_g, exp_r);
      end
      if (k > 0) begin
        exp_d = (k % 2 == 1) ? ref_mem[1][1][16'hC000] : ref_mem[1][0][16'h0010];
        n_checks++;
        if (rd[1] !== exp_d) begin
          n_fail++;
          $display("FAIL round_robin_data[%0d]: got %h required %h", k, rd[1], exp_d);
        end
      end
      step();
    end
  endtask

  task automatic test_boundaries();
    logic [15:0] addrs [4];
    logic [3:0]  exp_en [4];
    addrs  = '{16'hFF80, 16'hFFFE, 16'hFFFF, 16'h0000};
    exp_en = '{4'b0100, 4'b0100, 4'b0000, 4'b0000};
    for (int k = 0; k < 4; k++) begin
      drive((k < 3) ? 2'b01 : 2'b00, addrs[k], 16'h0000, 2'b00, 8'h00, 8'h00);
      n_checks++;
      if (en[0] !== exp_en[k]) begin
        n_fail++;
        $display("FAIL boundary_en[%0d]: got %b required %b", k, en[0], exp_en[k]);
      end
      if (k > 0) begin
        n_checks++;
        if ({rv[0], rd[0]} !== {2'b01, (k == 3) ? 8'hFF : ref_mem[0][2][addrs[k-1]]}) begin
          n_fail++;
          $display("FAIL boundary_data[%0d]: got rv=%b rd=%h required rv=01 rd=%h", k, rv[0],
                   rd[0], (k == 3) ? 8'hFF : ref_mem[0][2][addrs[k-1]]);
        end
      end
      step();
    end
  endtask

  task automatic test_overlap();
    logic [15:0] addrs [3];
    logic [3:0]  exp_en [3];
    addrs  = '{16'h5000, 16'h4000, 16'h9000};
    exp_en = '{4'b0001, 4'b0001, 4'b1000};
    for (int k = 0; k < 3; k++) begin
      drive(2'b01, addrs[k], 16'h0000, 2'b00, 8'h00, 8'h00);
      n_checks++;
      if (en[1] !== exp_en[k]) begin
        n_fail++;
        $display("FAIL overlap_en[%0d]: got %b required %b", k, en[1], exp_en[k]);
      end
      step();
    end
    drive(2'b00, 16'h0000, 16'h0000, 2'b00, 8'h00, 8'h00);
    n_checks++;
    if (rd[1] !== ref_mem[1][3][16'h9000]) begin
      n_fail++;
      $display("FAIL overlap_data: got %h required %h", rd[1], ref_mem[1][3][16'h9000]);
    end
    step();
  endtask

  task automatic test_reset_mid_read();
    drive(2'b01, 16'hC123, 16'h0000, 2'b00, 8'h00, 8'h00);
    step();
    drive(2'b00, 16'h0000, 16'h0000, 2'b00, 8'h00, 8'h00);
    n_checks++;
    if ({rv[0], rv[1]} !== 4'b0101) begin
      n_fail++;
      $display("FAIL midread_before: got rv0=%b rv1=%b required 01 01", rv[0], rv[1]);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({rv[0], rv[1], rd[0], rd[1]} !== 20'h0) begin
      n_fail++;
      $display("FAIL midread_async_clear: got rv0=%b rv1=%b rd0=%h rd1=%h required all 0",
               rv[0], rv[1], rd[0], rd[1]);
    end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step();
    drive(2'b11, 16'hC000, 16'h0010, 2'b00, 8'h00, 8'h00);
    n_checks++;
    if ({gnt[0], gnt[1]} !== 4'b1001) begin
      n_fail++;
      $display("FAIL midread_after_gnt: got gnt0=%b gnt1=%b required 10 01", gnt[0], gnt[1]);
    end
    step();
    drive(2'b00, 16'h0000, 16'h0000, 2'b00, 8'h00, 8'h00);
    n_checks++;
    if ({rv[1], rd[1]} !== {2'b01, ref_mem[1][1][16'hC000]}) begin
      n_fail++;
      $display("FAIL midread_after_data: got rv=%b rd=%h required 01 %h", rv[1], rd[1],
               ref_mem[1][1][16'hC000]);
    end
    step();
  endtask

  task automatic test_random();
    int w, s, a;
    logic [1:0]  e_gnt, e_rv;
    logic [3:0]  e_en;
    logic [15:0] e_sa;
    logic        e_sw;
    logic [7:0]  e_swd, e_rd;
    for (int c = 0; c < 600; c++) begin
      drive(2'($urandom), pick_addr(), pick_addr(), 2'($urandom), 8'($urandom), 8'($urandom));
      for (int d = 0; d < 2; d++) begin
        e_gnt = 2'b00; e_en = 4'b0000; e_sa = 16'h0000; e_sw = 1'b0; e_swd = 8'h00;
        w = ref_winner(d, m_req);
        if (w >= 0) begin
          e_gnt = 2'(1 << w);
          a = int'(m_addr[w*16 +: 16]);
          s = ref_decode(d, a);
          if (s >= 0) begin
            e_en = 4'(1 << s); e_sa = 16'(a); e_sw = m_write[w]; e_swd = m_wdata[w*8 +: 8];
          end
        end
        e_rv = pend[d] ? 2'(1 << pend_m[d]) : 2'b00;
        e_rd = pend[d] ? pend_data[d] : last_rd[d];
        n_checks++;
        if ({gnt[d], en[d], sa[d], sw[d], swd[d], rv[d], rd[d]} !==
            {e_gnt, e_en, e_sa, e_sw, e_swd, e_rv, e_rd}) begin
          n_fail++;
          $display("FAIL random[%0d] dut%0d: got gnt=%b en=%b sa=%h sw=%b swd=%h rv=%b rd=%h required gnt=%b en=%b sa=%h sw=%b swd=%h rv=%b rd=%h",
                   c, d, gnt[d], en[d], sa[d], sw[d], swd[d], rv[d], rd[d],
                   e_gnt, e_en, e_sa, e_sw, e_swd, e_rv, e_rd);
        end
      end
      step();
    end
  endtask

  initial begin
    logic [7:0] v;
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 4; s++) begin
        for (int a = 0; a < 65536; a++) begin
          v = 8'($urandom);
          mem[d][s][a] = v;
          ref_mem[d][s][a] = v;
        end
      end
    end
    test_reset();
    test_single_master();
    test_unmapped();
    test_fixed_priority();
    test_round_robin();
    test_boundaries();
    test_overlap();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Parametrised system-bus interconnect; successor to the single-master, hard-coded address mux in the top level.
- Arbitrates NUM_MASTERS requesters (e.g. CPU, OAM DMA) onto one shared bus.
- Decodes addresses into NUM_SLAVES parameter-defined regions (cart, WRAM, HRAM, ...).
- Returns read data with a registered one-cycle latency, matching synchronous block RAM slaves.

Parameters:
- NUM_MASTERS, 2, number of requesting masters; index NUM_MASTERS-1 has highest fixed priority.
- NUM_SLAVES, 4, number of decoded regions.
- ADDR_W, 16, address width.
- DATA_W, 8, data width.
- SLV_BASE, packed NUM_SLAVES*ADDR_W, inclusive base address of each region; slave i at bits [i*ADDR_W +: ADDR_W].
- SLV_LIMIT, packed NUM_SLAVES*ADDR_W, inclusive limit address of each region.
- ARB_MODE, 0, arbitration mode: 0 = fixed priority, 1 = round-robin.
- OPEN_BUS, all ones, DATA_W read value returned for unmapped addresses.

Ports:
- clk  in  1  system clock (4 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- m_req  in  NUM_MASTERS  per-master request; held until granted.
- m_addr  in  NUM_MASTERS*ADDR_W  per-master address.
- m_write  in  NUM_MASTERS  per-master write strobe (1 = write).
- m_wdata  in  NUM_MASTERS*DATA_W  per-master write data.
- m_gnt  out  NUM_MASTERS  one-hot grant; request accepted this cycle.
- m_rvalid  out  NUM_MASTERS  one-hot; read data valid on m_rdata this cycle.
- m_rdata  out  DATA_W  shared read data.
- s_enable  out  NUM_SLAVES  one-hot slave select.
- s_addr  out  ADDR_W  shared slave address.
- s_write  out  1  shared write strobe.
- s_wdata  out  DATA_W  shared write data.
- s_rdata  in  NUM_SLAVES*DATA_W  per-slave registered read data.

Behaviour:
- Reset (reset_n low, asynchronous):
  - m_rvalid = 0, m_rdata = 0.
  - Latched read slave index cleared; latched unmapped flag = 0.
  - Round-robin pointer = 0.
  - m_gnt, s_enable, s_write forced 0 while reset_n is low.
- Arbitration, combinational in cycle N over masters with m_req = 1:
  - ARB_MODE 0: the highest index wins.
  - ARB_MODE 1: the first requester at or after the pointer wins, searching upward with wrap. After a grant, the pointer is set to winner+1, modulo NUM_MASTERS, on the next clk edge. The pointer is unchanged when there is no grant.
- Grant: exactly one m_gnt bit is high in cycle N for the winner; all others are 0. There is no grant if no request is active. The transaction completes in one cycle; there are no wait states and no lock.
- Decode:
  - Slave i matches if SLV_BASE[i] <= addr <= SLV_LIMIT[i], unsigned compare.
  - Overlapping regions resolve to the lowest matching index.
  - No match means unmapped.
- Slave drive in cycle N:
  - s_addr, s_write and s_wdata come from the winner.
  - s_enable has the matching slave bit set.
  - With no winner, or an unmapped address, s_enable = 0, s_write = 0 and s_addr/s_wdata = 0.
- Writes: complete at the cycle-N clk edge in the slave. There is no rvalid. Unmapped writes are silently dropped.
- Reads: at the edge ending cycle N, the arbiter latches the winner index, slave index and unmapped flag. In cycle N+1:
  - m_rvalid[winner] = 1.
  - m_rdata = s_rdata[latched slave], or OPEN_BUS if unmapped.
  - m_rdata holds its last value when m_rvalid = 0.
- Back-to-back: a new grant in N+1 is allowed while rvalid for N is shown. Its rvalid appears in N+2. Throughput is one transaction per cycle.
- Simultaneous requests: a loser keeps m_req high and is re-arbitrated the next cycle. A master that drops m_req before its grant gets no transaction.
- Reset mid-read (asserted in N+1): rvalid is cleared immediately; the read is lost with no replay.
- Address edges: addr == SLV_BASE and addr == SLV_LIMIT both match. The maximum address (0xFFFF) is decoded like any other address.

Test Plan:
- Single master, defaults with slave1 = 0xC000-0xFDFF: write 0xA5 to 0xC123, then read 0xC123 -> m_gnt[0] in the request cycle, m_rvalid[0] = 1 one cycle later, m_rdata = 0xA5.
- Unmapped read of 0xFEA0, and write to 0xFEA0 -> s_enable = 0 on both; read gives m_rvalid = 1, m_rdata = 0xFF; the write causes no slave change.
- ARB_MODE 0, both masters request every cycle for 4 cycles -> m_gnt = 2'b10 every cycle; master 0 is starved.
- ARB_MODE 1, both masters request continuously for 4 cycles -> grants alternate 01, 10, 01, 10 and m_rvalid follows one cycle behind.
- Boundaries: read 0xFF80 and 0xFFFE (HRAM base/limit) and 0xFFFF -> first two select the HRAM slave; 0xFFFF returns OPEN_BUS. Overlapping regions select the lower index.
- Assert reset_n low in the rvalid cycle of a read -> m_rvalid drops asynchronously to 0; after release, pointer = 0 and the next read behaves normally.
